// File: rtl/hyperbus_trx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_trx_arbiter
// Description : Round-robin arbiter sharing one HyperBus PHY transaction port.
//               Enforces an idle gap between transactions and a watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_trx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int NUM_CHIPS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_WIDTH = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int CS_W       = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    localparam int OWN_W      = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]              req_write_i,
    input  logic [NUM_REQ*BURST_WIDTH-1:0]  req_burst_i,
    input  logic [NUM_REQ*CS_W-1:0]         req_cs_i,
    output logic                            phy_valid_o,
    input  logic                            phy_ready_i,
    output logic [ADDR_WIDTH-1:0]           phy_addr_o,
    output logic                            phy_write_o,
    output logic [BURST_WIDTH-1:0]          phy_burst_o,
    output logic [NUM_CHIPS-1:0]            phy_cs_o,
    input  logic                            phy_done_i,
    output logic [OWN_W-1:0]                owner_o,
    output logic                            busy_o,
    output logic                            timeout_o
);

    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_ACTIVE = 2'd2;
    localparam logic [1:0] c_GAP    = 2'd3;

    localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [OWN_W-1:0] c_LAST_REQ = OWN_W'(NUM_REQ - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [OWN_W-1:0]       r_rr;
    logic [OWN_W-1:0]       r_owner;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_write;
    logic [BURST_WIDTH-1:0] r_burst;
    logic [NUM_CHIPS-1:0]   r_cs;
    logic [WD_W-1:0]        r_wd_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;

    logic [NUM_REQ-1:0]     w_rr_mask;
    logic [NUM_REQ-1:0]     w_valid_hi;
    logic                   w_any_valid;
    logic [OWN_W-1:0]       w_gnt_idx;
    logic                   w_accept;
    logic                   w_wd_expire;
    logic [NUM_CHIPS-1:0]   w_cs_dec;

    logic [ADDR_WIDTH-1:0]  w_addr  [NUM_REQ];
    logic [BURST_WIDTH-1:0] w_burst [NUM_REQ];
    logic [CS_W-1:0]        w_cs    [NUM_REQ];

    // Per-requester views of the flattened request buses, plus the RR mask
    // selecting requesters at or after the pointer and the one-hot ready.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_addr[gi]      = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_burst[gi]     = req_burst_i[gi*BURST_WIDTH +: BURST_WIDTH];
            assign w_cs[gi]        = req_cs_i[gi*CS_W +: CS_W];
            assign w_rr_mask[gi]   = (OWN_W'(gi) >= r_rr);
            assign req_ready_o[gi] = w_accept && (w_gnt_idx == OWN_W'(gi));
        end
    endgenerate

    assign w_valid_hi  = req_valid_i & w_rr_mask;
    assign w_any_valid = |req_valid_i;
    assign w_accept    = (r_state == c_IDLE) && w_any_valid;
    assign w_wd_expire = (r_wd_cnt == c_WD_LAST);

    // Lowest set bit at/after the pointer wins; otherwise wrap to the lowest valid.
    always_comb begin
        w_gnt_idx = '0;
        if (|w_valid_hi) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_valid_hi[i]) w_gnt_idx = OWN_W'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid_i[i]) w_gnt_idx = OWN_W'(i);
            end
        end
    end

    // Out-of-range chip index decodes to no chip select at all.
    genvar gc;
    generate
        for (gc = 0; gc < NUM_CHIPS; gc++) begin : g_cs_dec
            assign w_cs_dec[gc] = (w_cs[w_gnt_idx] == CS_W'(gc));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any_valid) w_state_nxt = c_ISSUE;
            end
            c_ISSUE: begin
                if (phy_ready_i) w_state_nxt = c_ACTIVE;
            end
            c_ACTIVE: begin
                if (phy_done_i || w_wd_expire) begin
                    w_state_nxt = (GAP_CYCLES > 0) ? c_GAP : c_IDLE;
                end
            end
            c_GAP: begin
                if (r_gap_cnt == '0) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        phy_valid_o = 1'b0;
        busy_o      = 1'b1;
        timeout_o   = 1'b0;
        case (r_state)
            c_IDLE:   busy_o      = 1'b0;
            c_ISSUE:  phy_valid_o = 1'b1;
            c_ACTIVE: timeout_o   = w_wd_expire && !phy_done_i;
            default:  busy_o      = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr    <= '0;
            r_owner <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_burst <= '0;
            r_cs    <= '0;
        end else if (w_accept) begin
            r_rr    <= (w_gnt_idx == c_LAST_REQ) ? '0 : w_gnt_idx + OWN_W'(1);
            r_owner <= w_gnt_idx;
            r_addr  <= w_addr[w_gnt_idx];
            r_write <= req_write_i[w_gnt_idx];
            r_burst <= w_burst[w_gnt_idx];
            r_cs    <= w_cs_dec;
        end
    end

    // Watchdog is held clear while issuing so ACTIVE always starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_ISSUE) begin
            r_wd_cnt <= '0;
        end else if ((r_state == c_ACTIVE) && !w_wd_expire) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gap_cnt <= '0;
        end else if (r_state == c_ACTIVE) begin
            r_gap_cnt <= c_GAP_LOAD;
        end else if ((r_state == c_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    assign phy_addr_o  = r_addr;
    assign phy_write_o = r_write;
    assign phy_burst_o = r_burst;
    assign phy_cs_o    = r_cs;
    assign owner_o     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_trx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperbus_trx_arbiter
// Description : Scoreboard bench for hyperbus_trx_arbiter with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperbus_trx_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [7:0]  burst;
        logic [1:0]  cs;
        logic        owner;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_write;
    logic [15:0] req_burst;
    logic [1:0]  req_cs;
    logic        phy_valid;
    logic        phy_ready;
    logic [31:0] phy_addr;
    logic        phy_write;
    logic [7:0]  phy_burst;
    logic [1:0]  phy_cs;
    logic        phy_done;
    logic        owner;
    logic        busy;
    logic        timeout;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   to_seen  = 0;
    txn_t exp_q[$];

    hyperbus_trx_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_burst_i (req_burst),
        .req_cs_i    (req_cs),
        .phy_valid_o (phy_valid),
        .phy_ready_i (phy_ready),
        .phy_addr_o  (phy_addr),
        .phy_write_o (phy_write),
        .phy_burst_o (phy_burst),
        .phy_cs_o    (phy_cs),
        .phy_done_i  (phy_done),
        .owner_o     (owner),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w,
                           input logic [7:0] b, input logic c);
        req_addr[i*32 +: 32] = a;
        req_write[i]         = w;
        req_burst[i*8 +: 8]  = b;
        req_cs[i]            = c;
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [7:0] b,
                                input logic [1:0] cs, input logic own);
        txn_t t;
        t.addr = a; t.write = w; t.burst = b; t.cs = cs; t.owner = own;
        return t;
    endfunction

    // Monitor: every PHY handshake is matched against the next expected transaction.
    always @(negedge clk) begin
        if (rst_n && phy_valid && phy_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got addr 0x%0h owner %0d, required no issue",
                         phy_addr, owner);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("issue_addr",  phy_addr,  e.addr);
                chk("issue_write", phy_write, e.write);
                chk("issue_burst", phy_burst, e.burst);
                chk("issue_cs",    phy_cs,    e.cs);
                chk("issue_owner", owner,     e.owner);
            end
        end
        if (rst_n && timeout) to_seen++;
    end

    task automatic wait_issue(input string name);
        int n = 0;
        @(negedge clk);
        while (!phy_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!phy_valid) begin
            n_checks++;
            $display("FAIL %s_wait_issue: got phy_valid 0, required 1 within 100 cycles", name);
        end
    endtask

    // Ends on the negedge of the first GAP cycle.
    task automatic run_txn(input string name, input int active_cycles, input bit drop);
        wait_issue(name);
        tick();
        if (drop) req_valid = '0;
        repeat (active_cycles - 1) tick();
        phy_done = 1'b1;
        tick();
        phy_done = 1'b0;
        @(negedge clk);
        chk({name, "_gap_no_ready"}, req_ready, 2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int g;
        int n;
        int bad;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_burst = '0;
        req_cs    = '0;
        phy_ready = 1'b0;
        phy_done  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_phy_valid", phy_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_timeout",   timeout,   0);
        chk("rst_phy_addr",  phy_addr,  0);
        chk("rst_phy_cs",    phy_cs,    0);
        chk("rst_owner",     owner,     0);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0, PHY ready immediately.
        set_req(0, 32'h100, 1'b1, 8'd15, 1'b0);
        phy_ready = 1'b1;
        req_valid = 2'b01;
        exp_q.push_back(mk(32'h100, 1'b1, 8'd15, 2'b01, 1'b0));
        @(negedge clk);
        chk("t1_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_phy_valid", phy_valid, 1);
        tick();
        phy_done = 1'b1;
        @(negedge clk);
        chk("t1_active_no_valid", phy_valid, 0);
        tick();
        phy_done = 1'b0;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) g++;
        end
        chk("t1_gap_len", g, 4);
        chk("t1_q_empty", exp_q.size(), 0);

        // Both requesters continuously valid from a fresh pointer.
        do_reset();
        set_req(0, 32'h2000, 1'b0, 8'd3, 1'b1);
        set_req(1, 32'h3004, 1'b1, 8'd7, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(32'h2000, 1'b0, 8'd3, 2'b10, 1'b0));
            exp_q.push_back(mk(32'h3004, 1'b1, 8'd7, 2'b01, 1'b1));
        end
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) run_txn("t2", 2, i == 3);
        chk("t2_q_empty", exp_q.size(), 0);

        // PHY stalls in ISSUE while another requester waits.
        tick();
        phy_ready = 1'b0;
        set_req(1, 32'h4000_0040, 1'b0, 8'd0, 1'b1);
        exp_q.push_back(mk(32'h4000_0040, 1'b0, 8'd0, 2'b10, 1'b1));
        req_valid = 2'b10;
        wait_issue("t3");
        tick();
        req_valid = 2'b01;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!phy_valid || phy_addr !== 32'h4000_0040 || phy_cs !== 2'b10 ||
                req_ready !== 2'b00 || owner !== 1'b1) bad++;
            tick();
        end
        chk("t3_stall_stable", bad, 0);
        req_valid = '0;
        phy_ready = 1'b1;
        run_txn("t3", 2, 1'b1);
        chk("t3_q_empty", exp_q.size(), 0);

        // Watchdog abort, then the queued requester is served.
        tick();
        set_req(0, 32'h8000, 1'b1, 8'd31, 1'b0);
        set_req(1, 32'h9000, 1'b0, 8'd1, 1'b1);
        exp_q.push_back(mk(32'h8000, 1'b1, 8'd31, 2'b01, 1'b0));
        exp_q.push_back(mk(32'h9000, 1'b0, 8'd1, 2'b10, 1'b1));
        req_valid = 2'b01;
        wait_issue("t4");
        tick();
        req_valid = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout && n < 1100);
        chk("t4_wd_len", n, 1024);
        run_txn("t4_next", 3, 1'b1);
        chk("t4_one_pulse", to_seen, 1);
        chk("t4_q_empty", exp_q.size(), 0);

        // Done coincides with watchdog expiry: no abort pulse.
        tick();
        set_req(0, 32'hA0, 1'b0, 8'd2, 1'b0);
        exp_q.push_back(mk(32'hA0, 1'b0, 8'd2, 2'b01, 1'b0));
        req_valid = 2'b01;
        wait_issue("t5");
        tick();
        req_valid = '0;
        repeat (1023) tick();
        phy_done = 1'b1;
        @(negedge clk);
        chk("t5_no_timeout", timeout, 0);
        tick();
        phy_done = 1'b0;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) g++;
        end
        chk("t5_gap_len", g, 4);
        tick();
        phy_done = 1'b1;
        @(negedge clk);
        chk("t5_spurious_busy", busy, 0);
        tick();
        phy_done = 1'b0;
        @(negedge clk);
        chk("t5_spurious_idle", busy, 0);
        chk("t5_pulses", to_seen, 1);

        // Asynchronous reset while ACTIVE.
        tick();
        set_req(0, 32'h1234_5678, 1'b1, 8'hA5, 1'b1);
        exp_q.push_back(mk(32'h1234_5678, 1'b1, 8'hA5, 2'b10, 1'b0));
        req_valid = 2'b01;
        wait_issue("t6");
        tick();
        req_valid = '0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",  busy,      0);
        chk("t6_rst_addr",  phy_addr,  0);
        chk("t6_rst_write", phy_write, 0);
        chk("t6_rst_burst", phy_burst, 0);
        chk("t6_rst_cs",    phy_cs,    0);
        chk("t6_rst_owner", owner,     0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_req(1, 32'h55AA, 1'b1, 8'd4, 1'b0);
        exp_q.push_back(mk(32'h55AA, 1'b1, 8'd4, 2'b01, 1'b1));
        req_valid = 2'b10;
        @(negedge clk);
        chk("t6_req1_ready", req_ready, 2'b10);
        run_txn("t6", 2, 1'b1);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
